// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared FSM encoding and pipeline control vectors for the stall controller
package ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  typedef enum logic [1:0] {
    S_RUN      = RUN,
    S_MEM_WAIT = MEM_WAIT,
    S_HALT     = HALT
  } state_e;

  // One bit per pipeline-register control; packed MSB first in this order.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_bubble;
    logic ex_mem_we;
    logic mem_wb_bubble;
  } ctrl_t;

  // Zeroed control word: nothing loads, nothing is flushed.
  localparam ctrl_t CTRL_NOP = '0;

  // Normal flow: every register loads, no bubbles.
  localparam ctrl_t CTRL_PASS = '{
    pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
    id_ex_we: 1'b1, id_ex_bubble: 1'b0, ex_mem_we: 1'b1,
    mem_wb_bubble: 1'b0
  };

  // Whole pipe frozen behind MEM; WB receives a bubble so nothing retires twice.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
    id_ex_we: 1'b0, id_ex_bubble: 1'b0, ex_mem_we: 1'b0,
    mem_wb_bubble: 1'b1
  };

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit counter that increments on inc and sticks at all-ones
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer and memory watchdog for the 5-stage pipeline
//   clk, rst                 : clock, synchronous active-high reset
//   lu_hazard                : load-use hazard on the ID instruction
//   ex_branch_taken          : EX redirects the PC
//   mem_req, mem_ready       : data-memory access and its completion
//   pc_write_en .. mem_wb_bubble : per-register enables / flushes / bubbles
//   halted                   : watchdog tripped; cleared only by rst
//   stall_cnt, flush_cnt     : saturating performance counters
import ctrl_pkg::*;

module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_hazard,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_write_en,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit WDOG_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_stall;
  ctrl_t             ctrl;
  logic              stall_inc;
  logic              flush_inc;

  assign mem_stall = mem_req & ~mem_ready;

  // Watchdog FSM. wait_cnt holds the number of consecutive stall cycles
  // already completed, so the edge closing the MEM_TIMEOUT-th one sees
  // wait_cnt == MEM_TIMEOUT-1.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_RUN: begin
        wait_cnt_d = mem_stall ? WAIT_W'(1) : '0;
        if (mem_stall) begin
          // A one-cycle timeout trips on the very first stall cycle.
          state_d = (WDOG_EN && (WAIT_LAST == '0)) ? S_HALT : S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (WDOG_EN && (wait_cnt_q == WAIT_LAST)) begin
          state_d = S_HALT;
        end else if (wait_cnt_q != WAIT_MAX) begin
          // Hold at the top when the watchdog is disabled rather than wrap.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Priority decode. A stalled memory freezes everything, so a pending
  // branch or load-use simply waits in place and is seen again on release.
  always_comb begin
    ctrl      = CTRL_PASS;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state_q == S_HALT) begin
      ctrl      = CTRL_FREEZE;
      stall_inc = 1'b1;
    end else if (mem_stall) begin
      ctrl      = CTRL_FREEZE;
      stall_inc = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so its load-use is moot.
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      flush_inc         = 1'b1;
    end else if (lu_hazard) begin
      ctrl.pc_we        = 1'b0;
      ctrl.if_id_we     = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
      stall_inc         = 1'b1;
    end
  end

  assign pc_write_en     = ctrl.pc_we;
  assign if_id_write_en  = ctrl.if_id_we;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_write_en  = ctrl.id_ex_we;
  assign id_ex_bubble    = ctrl.id_ex_bubble;
  assign ex_mem_write_en = ctrl.ex_mem_we;
  assign mem_wb_bubble   = ctrl.mem_wb_bubble;
  assign halted          = (state_q == S_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] E_PASS = 7'b1101010;
  localparam logic [6:0] E_LU   = 7'b0001110;
  localparam logic [6:0] E_BR   = 7'b1111110;
  localparam logic [6:0] E_FRZ  = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  logic lu_hazard;
  logic ex_branch_taken;
  logic mem_req;
  logic mem_ready;

  always #5 clk = ~clk;

  // Instance A: defaults (MEM_TIMEOUT=16, CNT_W=16)
  logic a_pc, a_ifwe, a_iff, a_idwe, a_idb, a_exwe, a_mwb, a_halted;
  logic [15:0] a_stall, a_flush;
  // Instance B: MEM_TIMEOUT=4
  logic b_pc, b_ifwe, b_iff, b_idwe, b_idb, b_exwe, b_mwb, b_halted;
  logic [15:0] b_stall, b_flush;
  // Instance C: CNT_W=3
  logic c_pc, c_ifwe, c_iff, c_idwe, c_idb, c_exwe, c_mwb, c_halted;
  logic [2:0] c_stall, c_flush;

  pipeline_stall_controller dut_a (
    .clk(clk), .rst(rst), .lu_hazard(lu_hazard), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(a_pc), .if_id_write_en(a_ifwe), .if_id_flush(a_iff),
    .id_ex_write_en(a_idwe), .id_ex_bubble(a_idb), .ex_mem_write_en(a_exwe),
    .mem_wb_bubble(a_mwb), .halted(a_halted), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .lu_hazard(lu_hazard), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(b_pc), .if_id_write_en(b_ifwe), .if_id_flush(b_iff),
    .id_ex_write_en(b_idwe), .id_ex_bubble(b_idb), .ex_mem_write_en(b_exwe),
    .mem_wb_bubble(b_mwb), .halted(b_halted), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .lu_hazard(lu_hazard), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(c_pc), .if_id_write_en(c_ifwe), .if_id_flush(c_iff),
    .id_ex_write_en(c_idwe), .id_ex_bubble(c_idb), .ex_mem_write_en(c_exwe),
    .mem_wb_bubble(c_mwb), .halted(c_halted), .stall_cnt(c_stall), .flush_cnt(c_flush)
  );

  logic [6:0] a_ctrl, b_ctrl;
  assign a_ctrl = {a_pc, a_ifwe, a_iff, a_idwe, a_idb, a_exwe, a_mwb};
  assign b_ctrl = {b_pc, b_ifwe, b_iff, b_idwe, b_idb, b_exwe, b_mwb};

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic br, input logic req, input logic rdy);
    lu_hazard       = lu;
    ex_branch_taken = br;
    mem_req         = req;
    mem_ready       = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // Reset state with idle inputs
    check("reset_ctrl", 32'(a_ctrl), 32'(E_PASS));
    check("reset_stall", 32'(a_stall), 32'd0);
    check("reset_flush", 32'(a_flush), 32'd0);
    check("reset_halted", 32'(a_halted), 32'd0);

    // Load-use for one cycle
    set_in(1, 0, 0, 0);
    check("lu_ctrl", 32'(a_ctrl), 32'(E_LU));
    tick();
    set_in(0, 0, 0, 0);
    check("lu_stall_cnt", 32'(a_stall), 32'd1);
    check("lu_release_ctrl", 32'(a_ctrl), 32'(E_PASS));

    // Branch and load-use together: branch wins, no stall count
    set_in(1, 1, 0, 0);
    check("br_lu_ctrl", 32'(a_ctrl), 32'(E_BR));
    tick();
    set_in(0, 0, 0, 0);
    check("br_flush_cnt", 32'(a_flush), 32'd1);
    check("br_stall_cnt", 32'(a_stall), 32'd1);

    // Zero-wait memory: no stall
    set_in(0, 0, 1, 1);
    check("zero_wait_ctrl", 32'(a_ctrl), 32'(E_PASS));
    tick();
    check("zero_wait_stall", 32'(a_stall), 32'd1);

    // Three stall cycles, ready on the 4th (the would-be timeout cycle for B)
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 0);
      check($sformatf("memstall_ctrl_%0d", i), 32'(a_ctrl), 32'(E_FRZ));
      tick();
    end
    set_in(0, 0, 1, 1);
    check("mem_release_ctrl", 32'(a_ctrl), 32'(E_PASS));
    check("b_release_ctrl", 32'(b_ctrl), 32'(E_PASS));
    tick();
    check("mem_stall_cnt", 32'(a_stall), 32'd4);
    check("b_no_halt_on_ready", 32'(b_halted), 32'd0);

    // Request drops mid-wait, then a fresh run of 4 stalls trips B's watchdog
    set_in(0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0);
    tick();
    tick();
    tick();
    check("b_3_stalls_not_halted", 32'(b_halted), 32'd0);
    tick();
    check("b_halted_after_4", 32'(b_halted), 32'd1);
    check("a_not_halted", 32'(a_halted), 32'd0);
    check("a_stall_cnt_10", 32'(a_stall), 32'd10);
    set_in(0, 0, 1, 1);
    check("b_halt_ctrl", 32'(b_ctrl), 32'(E_FRZ));
    check("a_ctrl_after_ready", 32'(a_ctrl), 32'(E_PASS));
    tick();
    tick();
    set_in(0, 1, 0, 0);
    check("b_halt_ignores_branch", 32'(b_ctrl), 32'(E_FRZ));
    check("b_still_halted", 32'(b_halted), 32'd1);
    set_in(0, 0, 0, 0);

    // Reset out of HALT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b_reset_halted", 32'(b_halted), 32'd0);
    check("b_reset_ctrl", 32'(b_ctrl), 32'(E_PASS));
    check("b_reset_stall", 32'(b_stall), 32'd0);

    // Saturation on the 3-bit instance
    set_in(1, 0, 0, 0);
    repeat (10) tick();
    set_in(0, 0, 0, 0);
    check("c_stall_saturated", 32'(c_stall), 32'd7);
    check("a_stall_cnt_lu10", 32'(a_stall), 32'd10);
    check("c_flush_zero", 32'(c_flush), 32'd0);

    // Reset during MEM_WAIT
    set_in(0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mw_reset_ctrl", 32'(a_ctrl), 32'(E_PASS));
    check("mw_reset_stall", 32'(a_stall), 32'd0);
    set_in(0, 0, 1, 0);
    repeat (3) tick();
    check("b_wait_cleared_by_rst", 32'(b_halted), 32'd0);
    tick();
    check("b_halt_after_rst_wait", 32'(b_halted), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RV32I pipeline. It combines the load-use hazard flag from ID, taken-branch/jump redirects resolved in EX, and the wait handshake of the multi-cycle data memory. From these it drives the write enables, flushes and bubbles of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also runs a memory-wait watchdog that halts the core on a hung memory, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, consecutive memory-stall cycles before halting; 0 disables the watchdog
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- lu_hazard  in  1  load-use hazard detected for the instruction in ID
- ex_branch_taken  in  1  branch/jump in EX redirects the PC
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC register load enable
- if_id_write_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_write_en  out  1  ID/EX load enable
- id_ex_bubble  out  1  ID/EX loads zeroed control (NOP)
- ex_mem_write_en  out  1  EX/MEM load enable
- mem_wb_bubble  out  1  MEM/WB loads zeroed control
- halted  out  1  watchdog fired; core frozen until rst
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes

## Operation
- mem_stall = mem_req & ~mem_ready, combinational.
- Output decode is combinational from state and inputs. Priority is highest first:
  1. HALT: all write enables 0, mem_wb_bubble=1, flush/bubble to ID/EX and IF/ID 0.
  2. mem_stall: pc/if_id/id_ex/ex_mem write enables 0, mem_wb_bubble=1. Branch and load-use are ignored this cycle. They remain in their stages and are re-evaluated after release.
  3. ex_branch_taken: all write enables 1, if_id_flush=1, id_ex_bubble=1. This takes priority over lu_hazard because the ID instruction is squashed.
  4. lu_hazard: pc_write_en=0, if_id_write_en=0, id_ex_write_en=1, id_ex_bubble=1, ex_mem_write_en=1.
  5. Otherwise: all write enables 1, all flush/bubble 0.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN → MEM_WAIT when mem_stall.
  - MEM_WAIT → RUN when ~mem_stall.
  - MEM_WAIT → HALT on the edge ending the MEM_TIMEOUT-th consecutive mem_stall cycle (MEM_TIMEOUT≠0).
  - HALT is left only by rst.
- wait_cnt (internal):
  - In RUN it loads 1 if mem_stall, else 0.
  - In MEM_WAIT it increments while mem_stall.
  - The HALT condition is wait_cnt == MEM_TIMEOUT-1 with mem_stall.
  - Width is clog2(MEM_TIMEOUT+1), minimum 1.
- stall_cnt += 1 on every cycle decoding to case 1, 2 or 4. flush_cnt += 1 on every case-3 cycle. Both saturate at all-ones and never wrap.
- halted = (state == HALT).

## Timing
- While rst is high at an edge: state←RUN, wait_cnt←0, stall_cnt←0, flush_cnt←0.
- Output values after reset with inputs idle: all write enables 1, all flush/bubble 0, halted 0, counters 0.
- Combinational path from inputs to enables/flushes has zero latency. Counters and halted update one edge after the causing cycle.
- Zero-wait memory (mem_req & mem_ready in the same cycle) causes no stall and no state change.
- mem_ready arriving in the would-be timeout cycle means no stall, so the FSM goes to RUN, not HALT.
- mem_req dropping mid-wait counts as release: the FSM goes to RUN and wait_cnt clears.
- rst during MEM_WAIT or HALT: the FSM returns to RUN at that edge.
- Branch and load-use in the same cycle: branch handling only (case 3). stall_cnt does not increment.

## Structure
- Shared package ctrl_pkg holds:
  - state encoding localparams: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2
  - the NOP/zero control constant used by the bubble muxes
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated for stall_cnt and flush_cnt.

## Test plan
- Reset, idle inputs for 5 cycles → all enables 1, flush/bubble 0, stall_cnt=0, flush_cnt=0, halted=0.
- lu_hazard=1 for one cycle → pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, ex_mem_write_en=1; stall_cnt=1 next cycle.
- lu_hazard=1 and ex_branch_taken=1 together → if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1, MEM_TIMEOUT=16 → 3 cycles of all enables 0 with mem_wb_bubble=1, then normal; stall_cnt=3; FSM back in RUN.
- mem_req=1, mem_ready=0 held, MEM_TIMEOUT=4 → halted=1 after the 4th stall edge; stays 1 with all enables 0 despite later mem_ready=1, until rst.
- CNT_W=3 with lu_hazard held 10 cycles → stall_cnt stops at 7.
